// File: rtl/bank_stream_rd_pkg.sv
// Shared types and defaults for the bank read streamer.
// Imported by the sequencer and its skid FIFO.
package bank_stream_rd_pkg;

  localparam int W_DEF  = 128;
  localparam int A_DEF  = 9;
  localparam int LW_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/bank_skid_fifo.sv
// Two-entry skid buffer between bank read data and the stream.
// Push and pop may coincide even when full; flush wins over both.
module bank_skid_fifo
  import bank_stream_rd_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wp;
  logic         rp;
  logic [1:0]   cnt;

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else if (flush) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) wp <= ~wp;
      if (pop)  rp <= ~rp;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // storage; contents need no reset
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wp] <= wdata;
  end

  assign rdata = mem[rp];
  assign count = cnt;

endmodule

// File: rtl/bank_stream_rd.sv
// Strided read sequencer for one bank read port.
// Retries lost grants and streams words out in order.
module bank_stream_rd
  import bank_stream_rd_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int A  = A_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [A-1:0]  cfg_base,
  input  logic [A-1:0]  cfg_stride,
  input  logic [LW-1:0] cfg_len,
  output logic          busy,
  output logic          done,
  output logic          bank_csel,
  output logic          bank_en,
  output logic [A-1:0]  bank_addr,
  input  logic          bank_grnt,
  input  logic [W-1:0]  bank_word,
  output logic [W-1:0]  out_word,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready
);

  state_t        state;
  state_t        state_n;
  logic [A-1:0]  addr;
  logic [A-1:0]  stride;
  logic [LW-1:0] remaining;
  logic [LW-1:0] pending;
  logic          inflight;
  logic          issue;
  logic          fire;
  logic          pop;
  logic          accept;
  logic          credit_ok;
  logic [1:0]    fcount;
  logic [2:0]    used;

  assign pop    = out_valid & out_ready;
  assign fire   = issue & bank_grnt;
  assign accept = (state == ST_IDLE) & start & ~abort;

  // a pop this cycle frees the slot a new read will need
  assign used      = {1'b0, fcount} + {2'b0, inflight};
  assign credit_ok = used < (3'd2 + {2'b0, pop});

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // next state and bank request
  always_comb begin
    state_n = state;
    issue   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start)
          state_n = (cfg_len == '0) ? ST_DONE
                                    : ST_ISSUE;
      end
      ST_ISSUE: begin
        issue = credit_ok & ~abort;
        if (issue && bank_grnt &&
            remaining == LW'(1))
          state_n = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && pending == LW'(1))
          state_n = ST_DONE;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    if (abort) state_n = ST_IDLE;
  end

  // address generator, counters, in-flight flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr      <= '0;
      stride    <= '0;
      remaining <= '0;
      pending   <= '0;
      inflight  <= 1'b0;
    end else if (abort) begin
      inflight  <= 1'b0;
    end else begin
      inflight <= fire;
      if (accept) begin
        addr      <= cfg_base;
        stride    <= cfg_stride;
        remaining <= cfg_len;
        pending   <= cfg_len;
      end else begin
        if (fire) begin
          addr      <= addr + stride;
          remaining <= remaining - LW'(1);
        end
        if (pop) pending <= pending - LW'(1);
      end
    end
  end

  bank_skid_fifo #(
    .W (W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort),
    .push  (inflight),
    .wdata (bank_word),
    .pop   (pop),
    .rdata (out_word),
    .count (fcount)
  );

  assign bank_en   = issue;
  assign bank_csel = issue;
  assign bank_addr = addr;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign out_valid = (fcount != 2'd0);
  assign out_last  = out_valid &&
                     (pending == LW'(1));

endmodule

// File: tb/tb_bank_stream_rd.sv
// Directed bench for bank_stream_rd with a bank model,
// a transfer-level reference model and literal pins.
module tb_bank_stream_rd;

  localparam int W  = 128;
  localparam int A  = 9;
  localparam int LW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [A-1:0]  cfg_base;
  logic [A-1:0]  cfg_stride;
  logic [LW-1:0] cfg_len;
  logic          busy;
  logic          done;
  logic          bank_csel;
  logic          bank_en;
  logic [A-1:0]  bank_addr;
  logic          bank_grnt;
  logic [W-1:0]  bank_word;
  logic [W-1:0]  out_word;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;

  bank_stream_rd #(.W(W), .A(A), .LW(LW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .cfg_base   (cfg_base),
    .cfg_stride (cfg_stride),
    .cfg_len    (cfg_len),
    .busy       (busy),
    .done       (done),
    .bank_csel  (bank_csel),
    .bank_en    (bank_en),
    .bank_addr  (bank_addr),
    .bank_grnt  (bank_grnt),
    .bank_word  (bank_word),
    .out_word   (out_word),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] word_of(input int a);
    logic [31:0] t;
    t = 32'hC0DE_0000 | 32'(a);
    return {t, ~t, t ^ 32'h5A5A_5A5A, t + 32'd7};
  endfunction

  // bank: registered read, word valid the cycle after grant
  always @(posedge clk) begin
    if (bank_en && bank_grnt)
      bank_word <= word_of(int'(bank_addr));
    else
      bank_word <= {$urandom, $urandom,
                    $urandom, $urandom};
  end

  int errors = 0;
  int checks = 0;

  // reference model of one transfer
  int m_base, m_stride, m_len;
  int n_grant, n_pop;
  bit m_busy, m_done;
  bit hold;
  logic [W-1:0] held_word;
  int cyc, start_cyc;

  // per-transfer observations
  int gaddr[$];
  int en_cycles, max_out, first_valid;
  int last_pop, done_rel, done_cnt;
  int busy_cycles, pop_cnt;

  function automatic int exp_addr(input int i);
    return (m_base + i * m_stride) % (1 << A);
  endfunction

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm,
                      input logic [W-1:0] act,
                      input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // compare DUT to model, then advance model over the edge
  task automatic step();
    int ri;
    bit nb, nd;
    ri = cyc - start_cyc;
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("csel", bank_csel, bank_en);
    if (!m_busy) begin
      chk("idle_en", bank_en, 0);
      chk("idle_valid", out_valid, 0);
    end
    if (bank_en) begin
      chk("addr", bank_addr, exp_addr(n_grant));
      chk("overissue", n_grant < m_len, 1);
      chk("credit", (n_grant - n_pop) <= 2, 1);
      en_cycles++;
      if (n_grant - n_pop > max_out)
        max_out = n_grant - n_pop;
    end
    if (out_valid) begin
      chk("overpop", n_pop < m_len, 1);
      chkw("word", out_word,
           word_of(exp_addr(n_pop)));
      chk("last", out_last, n_pop == m_len - 1);
      if (first_valid < 0) first_valid = ri;
    end
    if (hold) begin
      chk("hold_valid", out_valid, 1);
      chkw("hold_word", out_word, held_word);
    end
    if (busy) busy_cycles++;
    if (done) begin
      done_cnt++;
      done_rel = ri;
    end
    nb = m_busy;
    nd = 1'b0;
    hold = 1'b0;
    if (abort) begin
      nb = 1'b0;
    end else if (!m_busy) begin
      if (start) begin
        m_base = int'(cfg_base);
        m_stride = int'(cfg_stride);
        m_len = int'(cfg_len);
        n_grant = 0;
        n_pop = 0;
        start_cyc = cyc + 1;
        gaddr.delete();
        en_cycles = 0;
        max_out = 0;
        first_valid = -1;
        last_pop = -1;
        done_rel = -1;
        done_cnt = 0;
        busy_cycles = 0;
        pop_cnt = 0;
        nb = 1'b1;
        nd = (m_len == 0);
      end
    end else if (m_done) begin
      nb = 1'b0;
    end else begin
      if (bank_en && bank_grnt) begin
        gaddr.push_back(int'(bank_addr));
        n_grant++;
      end
      if (out_valid && out_ready) begin
        pop_cnt++;
        n_pop++;
        last_pop = ri;
        if (n_pop == m_len) nd = 1'b1;
      end
      hold = out_valid && !out_ready;
      held_word = out_word;
    end
    m_busy = nb;
    m_done = nd;
    cyc++;
  endtask

  // one transfer; rel counts cycles from the first busy cycle
  task automatic run(input int base, stride, len,
                     input int deny_n,
                     input int stall_from, stall_n,
                     input int abort_at);
    int rel;
    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b0;
    cfg_base = A'(base);
    cfg_stride = A'(stride);
    cfg_len = LW'(len);
    bank_grnt = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    step();
    rel = 0;
    do begin
      @(posedge clk); #1;
      start = (rel == 1 && len > 1 && abort_at < 0);
      cfg_base = 9'h155;
      cfg_stride = 9'd7;
      cfg_len = 10'd5;
      bank_grnt = (rel >= deny_n);
      out_ready = !(rel >= stall_from &&
                    rel < stall_from + stall_n);
      abort = (rel == abort_at);
      @(negedge clk);
      step();
      rel++;
    end while (m_busy && rel < 200);
    if (m_busy) begin
      checks++;
      errors++;
      $display("FAIL timeout: got busy expected idle");
    end
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    bank_grnt = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    cfg_base = '0;
    cfg_stride = '0;
    cfg_len = '0;
    bank_grnt = 1'b1;
    out_ready = 1'b1;
    m_busy = 1'b0;
    m_done = 1'b0;
    hold = 1'b0;
    m_len = 0;
    n_grant = 0;
    n_pop = 0;
    cyc = 0;
    start_cyc = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_csel", bank_csel, 0);
    chk("rst_en", bank_en, 0);
    chk("rst_addr", bank_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    step();

    // 1: plain streaming
    run(0, 1, 4, 0, 999, 0, -1);
    chk("t1_first", first_valid, 2);
    chk("t1_lastpop", last_pop, 5);
    chk("t1_done", done_rel, 6);
    chk("t1_ndone", done_cnt, 1);
    chk("t1_busy", busy_cycles, 7);

    // 2: two lost grants at the start
    run(0, 1, 3, 2, 999, 0, -1);
    chk("t2_en", en_cycles, 5);
    chk("t2_n", gaddr.size(), 3);
    chk("t2_a0", gaddr[0], 0);
    chk("t2_a1", gaddr[1], 1);
    chk("t2_a2", gaddr[2], 2);

    // 3: consumer stall
    run(0, 1, 8, 0, 2, 6, -1);
    chk("t3_maxout", max_out, 2);
    chk("t3_pops", pop_cnt, 8);
    chk("t3_lastpop", last_pop, 15);

    // 4: address wrap
    run(510, 3, 3, 0, 999, 0, -1);
    chk("t4_n", gaddr.size(), 3);
    chk("t4_a0", gaddr[0], 510);
    chk("t4_a1", gaddr[1], 1);
    chk("t4_a2", gaddr[2], 4);

    // 5: empty transfer
    run(7, 1, 0, 0, 999, 0, -1);
    chk("t5_en", en_cycles, 0);
    chk("t5_busy", busy_cycles, 1);
    chk("t5_ndone", done_cnt, 1);

    // 6: abort with data buffered and in flight
    run(0, 1, 8, 0, 0, 10, 2);
    chk("t6_ndone", done_cnt, 0);
    chk("t6_busy", busy_cycles, 3);

    // then a clean transfer
    run(100, 2, 4, 0, 999, 0, -1);
    chk("t7_first", first_valid, 2);
    chk("t7_done", done_rel, 6);
    chk("t7_ndone", done_cnt, 1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
